// File: rtl/seq_tail_light_dimmer.sv
// Sequential turn/hazard tail-light controller with per-lamp PWM brightness ramps.
// Optional brake override input is compiled in with SEQ_TAIL_LIGHT_BRAKE_EN.
module seq_tail_light_dimmer #(
  parameter int LAMPS    = 3,
  parameter int STEPS    = 4,
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 2**20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
`ifdef SEQ_TAIL_LIGHT_BRAKE_EN
  input  logic               brake,
`endif
  output logic [2*LAMPS-1:0] light,
  output logic               busy
);

  localparam int LAST   = LAMPS*STEPS - 1;
  localparam int STEP_W = (LAMPS*STEPS > 1) ? $clog2(LAMPS*STEPS) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);

  // state | meaning: IDLE dark gap / waiting, RUN_L left ramp, RUN_R right ramp, RUN_H hazard
  typedef enum logic [1:0] {IDLE, RUN_L, RUN_R, RUN_H} state_t;

  state_t              state, state_next;
  logic [STEP_W-1:0]   step, step_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [LAMPS-1:0]    lamp_on, right_on, left_nx, right_nx;
  logic                busy_nx;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    if (tick) begin
      case (state)
        IDLE: begin
          step_next = '0;
          if (hazard)             state_next = RUN_H;
          else if (left ^ right)  state_next = left ? RUN_L : RUN_R;
        end
        default: begin
          if (step == STEP_W'(LAST)) begin
            state_next = IDLE;
            step_next  = '0;
          end else begin
            step_next = step + 1'b1;
          end
        end
      endcase
    end
  end

  // k counts how many steps lamp i has been ramping; STEPS or more means fully lit
  function automatic logic lamp_lit(input int k, input logic [PWM_BITS-1:0] cnt);
    if (k <= 0)     return 1'b0;
    if (k >= STEPS) return 1'b1;
    return int'(cnt) < ((k << PWM_BITS) / STEPS);
  endfunction

  for (genvar i = 0; i < LAMPS; i++) begin : g_lamp
    assign lamp_on[i]          = lamp_lit(int'(step) - i*STEPS + 1, pwm_cnt);
    assign right_on[LAMPS-1-i] = lamp_on[i];
  end

  always_comb begin
    left_nx  = '0;
    right_nx = '0;
    case (state)
      RUN_L:   left_nx  = lamp_on;
      RUN_R:   right_nx = right_on;
      RUN_H: begin
        left_nx  = lamp_on;
        right_nx = right_on;
      end
      default: ;
    endcase
`ifdef SEQ_TAIL_LIGHT_BRAKE_EN
    if (brake) begin
      if (state == IDLE || state == RUN_R) left_nx  = '1;
      if (state == IDLE || state == RUN_L) right_nx = '1;
    end
`endif
    busy_nx = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      light <= '0;
      busy  <= 1'b0;
    end else begin
      light <= {left_nx, right_nx};
      busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_seq_tail_light_dimmer.sv
// Randomized bench for seq_tail_light_dimmer against a cycle-level behavioural model.
// Define SEQ_TAIL_LIGHT_BRAKE_EN to exercise the brake override as well.
module tb_seq_tail_light_dimmer;

  localparam int LAMPS    = 3;
  localparam int STEPS    = 4;
  localparam int PWM_BITS = 8;
  localparam int TICK_DIV = 4;
  localparam int NSTEP    = LAMPS*STEPS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0;
  logic brake = 1'b0;
  logic [2*LAMPS-1:0] light;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_tail_light_dimmer #(
    .LAMPS(LAMPS), .STEPS(STEPS), .PWM_BITS(PWM_BITS), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .left(left),
    .right(right),
    .hazard(hazard),
`ifdef SEQ_TAIL_LIGHT_BRAKE_EN
    .brake(brake),
`endif
    .light(light),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: mode 0 idle, 1 left, 2 right, 3 hazard; time measured in cycles since reset.
  int  m_mode = 0;
  int  m_step = 0;
  int  m_cycle = 0;
  bit  m_valid = 0;
  logic [2*LAMPS-1:0] exp_light = '0;
  logic               exp_busy  = 1'b0;

  function automatic logic [2*LAMPS-1:0] model_light(input int mode, input int s, input int pwm, input bit brk);
    logic [2*LAMPS-1:0] r;
    bit on;
    int k;
    r = '0;
    for (int i = 0; i < LAMPS; i++) begin
      k = s - i*STEPS + 1;
      if (k >= STEPS)  on = 1;
      else if (k <= 0) on = 0;
      else             on = (pwm < (k * (1 << PWM_BITS)) / STEPS);
      if (mode == 1 || mode == 3) r[LAMPS+i]   = on;
      if (mode == 2 || mode == 3) r[LAMPS-1-i] = on;
      if (brk && (mode == 0 || mode == 2)) r[LAMPS+i]   = 1'b1;
      if (brk && (mode == 0 || mode == 1)) r[LAMPS-1-i] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit brk;
`ifdef SEQ_TAIL_LIGHT_BRAKE_EN
    brk = brake;
`else
    brk = 0;
`endif
    m_valid = 1;
    if (reset) begin
      exp_light = '0;
      exp_busy  = 1'b0;
      m_mode = 0; m_step = 0; m_cycle = 0;
    end else begin
      exp_light = model_light(m_mode, m_step, m_cycle % (1 << PWM_BITS), brk);
      exp_busy  = (m_mode != 0);
      if (m_cycle % TICK_DIV == TICK_DIV - 1) begin
        if (m_mode == 0) begin
          m_step = 0;
          if (hazard)              m_mode = 3;
          else if (left && !right) m_mode = 1;
          else if (right && !left) m_mode = 2;
        end else if (m_step == NSTEP - 1) begin
          m_mode = 0; m_step = 0;
        end else begin
          m_step++;
        end
      end
      m_cycle++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_eq("light", 32'(light), 32'(exp_light));
      check_eq("busy",  32'(busy),  32'(exp_busy));
    end
  end

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  task automatic set_in(input logic l, input logic r, input logic h);
    left = l; right = r; hazard = h;
  endtask

  initial begin
    int hold;
    // Reset for 2 clocks, then left held: busy after first tick, outputs one clk later.
    set_in(0, 0, 0);
    cycles(2);
    check_eq("reset_light", 32'(light), 32'h0);
    check_eq("reset_busy",  32'(busy),  32'h0);
    reset = 1'b0;
    set_in(1, 0, 0);
    cycles(6);
    check_eq("left_busy", 32'(busy), 32'h1);
    check_eq("left_right_group_dark", 32'(light[LAMPS-1:0]), 32'h0);
    cycles(60);
    set_in(0, 1, 0);
    cycles(120);
    set_in(1, 0, 1);
    cycles(70);
    set_in(1, 1, 0);
    cycles(60);
    check_eq("both_idle_light", 32'(light), 32'h0);
    check_eq("both_idle_busy",  32'(busy),  32'h0);
    // Mid-sequence input change must not disturb a running left sequence.
    set_in(1, 0, 0);
    cycles(20);
    set_in(1, 1, 0);
    cycles(40);
    // Reset at step 7 of a right sequence.
    reset = 1'b1; set_in(0, 1, 0);
    cycles(1);
    reset = 1'b0;
    cycles(TICK_DIV + 7*TICK_DIV + 2);
    reset = 1'b1;
    cycles(1);
    check_eq("abort_light", 32'(light), 32'h0);
    check_eq("abort_busy",  32'(busy),  32'h0);
    reset = 1'b0;
    cycles(120);
`ifdef SEQ_TAIL_LIGHT_BRAKE_EN
    brake = 1'b1; set_in(0, 0, 0);
    cycles(8);
    check_eq("brake_idle", 32'(light), 32'h3f);
    brake = 1'b0;
`endif
    hold = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 1999) == 0) reset = 1'b1;
      if (hold == 0) begin
        hazard = ($urandom_range(0, 5) == 0);
        left   = 1'($urandom_range(0, 1));
        right  = 1'($urandom_range(0, 1));
`ifdef SEQ_TAIL_LIGHT_BRAKE_EN
        brake  = ($urandom_range(0, 3) == 0);
`endif
        hold = $urandom_range(1, 80);
      end else begin
        hold--;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
